nonce_scheduler: RTL and testbench
==================================

Name: nonce_scheduler

Overview:
- Sequences the processor array through the nonce space for one block header.
- Each processor owns a contiguous partition; the scheduler issues one round per cycle to all lanes.
- Tracks in-flight rounds through the hash pipeline and converts the first success into an absolute 32-bit nonce.
- Reports found / not-found to the host side over a valid/ready handshake. Sits between the block-input interface and the processor array.

Parameters:
- NUMPROCESSORS, 10, number of hashing lanes.
- NONCESPACE, 64, total nonces per block (≤ 2^32).
- PIPE_DEPTH, 4, cycles from issue to the matching success_i (≥ 1).
- Derived constants:
  - NPP = NONCESPACE / NUMPROCESSORS
  - LEFTOVER = NONCESPACE − NPP·NUMPROCESSORS
  - NROUNDS = NPP + (LEFTOVER > 0)
  - ROUNDBITS = max(1, $clog2(NROUNDS))

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- block_valid_i  in  1  new block header available.
- block_ready_o  out  1  scheduler accepts a block this cycle.
- issue_valid_o  out  1  a round is issued this cycle.
- issue_round_o  out  ROUNDBITS  round index r.
- issue_lane_en_o  out  NUMPROCESSORS  lane p tests nonce base(p)+r.
- success_i  in  NUMPROCESSORS  per-lane hit, PIPE_DEPTH cycles after issue.
- result_valid_o  out  1  result available.
- result_ready_i  in  1  host consumes result.
- result_found_o  out  1  1 = nonce found, 0 = space exhausted.
- result_nonce_o  out  32  winning nonce (0 when not found).

Behaviour:
- Partition: count(p) = NPP + (p < LEFTOVER); base(p) = NPP·p + min(p, LEFTOVER). All arithmetic is 32-bit unsigned.
- Lane enable: issue_lane_en_o[p] = (r < count(p)) while issue_valid_o, else 0.
- Reset values: IDLE state; all outputs 0 except block_ready_o = 1. Delay line and result registers cleared.
- block_ready_o = 1 in IDLE, RUN and DRAIN; 0 in REPORT.
- FSM states: IDLE, RUN, DRAIN, REPORT.
- IDLE:
  - block_valid_i & block_ready_o at edge t → RUN with r = 0.
  - issue_valid_o is high in cycles t+1 … t+NROUNDS, with r incrementing 0 … NROUNDS−1.
- RUN → DRAIN: after issuing r = NROUNDS−1.
- Delay line: a PIPE_DEPTH-deep shift register carrying {valid, r, lane_en}. Its tail aligns with success_i.
- Hit qualification: hit = success_i & tail.lane_en & {tail.valid}. Hits on disabled lanes, or with no valid tail entry, are ignored.
- Any hit in RUN or DRAIN:
  - Winner is the lowest-index set lane p.
  - Capture nonce = base(p) + tail.r and found = 1.
  - Go to REPORT and stop issuing the same cycle.
  - Flush the delay line; later in-flight hits are discarded.
- DRAIN: lasts exactly PIPE_DEPTH cycles. With no hit, go to REPORT with found = 0, nonce = 0.
- REPORT:
  - result_valid_o = 1 with stable found and nonce until result_valid_o & result_ready_i.
  - After that handshake, go to IDLE on the next edge.
- Preemption: block_valid_i accepted in RUN or DRAIN aborts the current block.
  - Flush the delay line and restart at r = 0 (RUN).
  - A hit in that same cycle is dropped.
  - No result is reported for the aborted block.
- Reset mid-operation: immediate return to reset values; no result emitted.
- Wrap: r never exceeds NROUNDS−1.
- NONCESPACE = 2^32 is legal: base and nonce computed mod 2^32.

Decomposition:
- Package nonce_pkg holds:
  - constants NPP, LEFTOVER, NROUNDS, ROUNDBITS;
  - state enum sched_state_t;
  - inflight_t struct {valid, round, lane_en};
  - function base_of(p).
- One sub-module, nonce_inflight_tracker: the PIPE_DEPTH delay line with synchronous flush, which also produces the qualified hit vector.

Test Plan:
- Sweep, no hits (defaults):
  - block accepted at edge t → rounds 0..6 issued in cycles t+1..t+7;
  - round 6 issued with lane_en = 10'b00_0000_1111;
  - result_valid_o asserts at t+12 with found = 0, nonce = 0.
- Single hit: success_i[4] aligned to round 2 → found = 1, nonce = 30 (28+2); issue_valid_o drops the next cycle.
- Simultaneous hits: lanes 1 and 7 aligned to round 0 → nonce = 7 (lane 1 wins).
- Disabled-lane hit: success_i[5] aligned to round 6 → ignored; final result found = 0.
- Backpressure then preemption:
  - result_ready_i held low 5 cycles → result stays stable and block_ready_o = 0;
  - a new block_valid_i in RUN at r = 3 → restart at r = 0; the old block's hit at r = 3 is not reported.
- Async reset asserted mid-DRAIN → outputs return to reset values within the same cycle; no result emitted; next block runs normally.

Source files
------------

// File: rtl/nonce_pkg.sv
// nonce_pkg: configuration and shared types for the nonce scheduler.
//   NUMPROCESSORS / NONCESPACE / PIPE_DEPTH set the array geometry; the rest
//   is derived. Lane p owns nonces [base_of(p), base_of(p) + count_of(p)).
package nonce_pkg;

    typedef longint unsigned u64_t;

    localparam int   NUMPROCESSORS = 10;
    localparam u64_t NONCESPACE    = 64;
    localparam int   PIPE_DEPTH    = 4;

    localparam u64_t NPP       = NONCESPACE / u64_t'(NUMPROCESSORS);
    localparam u64_t LEFTOVER  = NONCESPACE - NPP * u64_t'(NUMPROCESSORS);
    localparam u64_t NROUNDS   = NPP + ((LEFTOVER > 0) ? 64'd1 : 64'd0);
    localparam int   ROUNDBITS = (NROUNDS <= 64'd2) ? 1 : $clog2(NROUNDS);
    localparam int   DRAINBITS = (PIPE_DEPTH <= 2) ? 1 : $clog2(PIPE_DEPTH);

    localparam logic [ROUNDBITS-1:0] LAST_ROUND = ROUNDBITS'(NROUNDS - 64'd1);
    localparam logic [DRAINBITS-1:0] LAST_DRAIN = DRAINBITS'(PIPE_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        REPORT = 2'd3
    } sched_state_t;

    typedef struct packed {
        logic                     valid;
        logic [ROUNDBITS-1:0]     round;
        logic [NUMPROCESSORS-1:0] lane_en;
    } inflight_t;

    function automatic u64_t count_of(input int p);
        return NPP + ((u64_t'(p) < LEFTOVER) ? 64'd1 : 64'd0);
    endfunction

    // Truncation to 32 bits keeps a full 2^32 nonce space wrapping correctly.
    function automatic logic [31:0] base_of(input int p);
        u64_t pp;
        pp = u64_t'(p);
        return 32'(NPP * pp + ((pp < LEFTOVER) ? pp : LEFTOVER));
    endfunction

    function automatic logic [NUMPROCESSORS-1:0] lane_en_of(input logic [ROUNDBITS-1:0] r);
        logic [NUMPROCESSORS-1:0] en;
        for (int p = 0; p < NUMPROCESSORS; p++)
            en[p] = (u64_t'(r) < count_of(p));
        return en;
    endfunction

endpackage

// File: rtl/nonce_inflight_tracker.sv
// nonce_inflight_tracker: PIPE_DEPTH-deep delay line of issued rounds whose
// tail lines up with success_i. Produces the qualified hit vector and the
// round number of the tail entry.
//   clk, rst   : clock, async active-high reset
//   flush      : clears every in-flight entry (takes priority over push)
//   push       : entry issued this cycle
//   success_i  : raw per-lane success from the processor array
//   hit        : success on lanes that were enabled for a valid tail entry
//   hit_round  : round index of the tail entry
module nonce_inflight_tracker
    import nonce_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  inflight_t                push,
    input  logic [NUMPROCESSORS-1:0] success_i,
    output logic [NUMPROCESSORS-1:0] hit,
    output logic [ROUNDBITS-1:0]     hit_round
);

    inflight_t line [PIPE_DEPTH];
    inflight_t tail;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PIPE_DEPTH; i++) line[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < PIPE_DEPTH; i++) line[i] <= '0;
        end else begin
            line[0] <= push;
            for (int i = 1; i < PIPE_DEPTH; i++) line[i] <= line[i-1];
        end
    end

    assign tail      = line[PIPE_DEPTH-1];
    assign hit       = success_i & tail.lane_en & {NUMPROCESSORS{tail.valid}};
    assign hit_round = tail.round;

endmodule

// File: rtl/nonce_scheduler.sv
// nonce_scheduler: walks the processor array through one block's nonce space,
// one round per cycle, and reports the first (lowest round, then lowest lane)
// success as an absolute nonce, or "not found" once the pipeline drains.
//   block_valid_i / block_ready_o          : new block handshake (preempts RUN/DRAIN)
//   issue_valid_o / issue_round_o / _lane_en_o : round broadcast to the lanes
//   success_i                              : per-lane hit, PIPE_DEPTH cycles after issue
//   result_valid_o / result_ready_i        : result handshake
//   result_found_o / result_nonce_o        : outcome, held stable while valid
module nonce_scheduler
    import nonce_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     block_valid_i,
    output logic                     block_ready_o,
    output logic                     issue_valid_o,
    output logic [ROUNDBITS-1:0]     issue_round_o,
    output logic [NUMPROCESSORS-1:0] issue_lane_en_o,
    input  logic [NUMPROCESSORS-1:0] success_i,
    output logic                     result_valid_o,
    input  logic                     result_ready_i,
    output logic                     result_found_o,
    output logic [31:0]              result_nonce_o
);

    sched_state_t             state, state_n;
    logic [ROUNDBITS-1:0]     round_q, round_n;
    logic [DRAINBITS-1:0]     drain_q, drain_n;
    logic                     found_q, found_n;
    logic [31:0]              nonce_q, nonce_n;
    logic                     flush;
    logic [NUMPROCESSORS-1:0] hit;
    logic [ROUNDBITS-1:0]     hit_round;
    logic [31:0]              win_nonce;
    inflight_t                push;

    assign issue_valid_o   = (state == RUN);
    assign issue_round_o   = issue_valid_o ? round_q : '0;
    assign issue_lane_en_o = issue_valid_o ? lane_en_of(round_q) : '0;
    assign block_ready_o   = (state != REPORT);
    assign result_valid_o  = (state == REPORT);
    assign result_found_o  = found_q;
    assign result_nonce_o  = nonce_q;

    assign push = '{valid: issue_valid_o, round: round_q, lane_en: issue_lane_en_o};

    nonce_inflight_tracker u_tracker (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (push),
        .success_i (success_i),
        .hit       (hit),
        .hit_round (hit_round)
    );

    // Descending scan so the lowest-index hit lane is the one that sticks.
    always_comb begin
        win_nonce = '0;
        for (int p = NUMPROCESSORS - 1; p >= 0; p--)
            if (hit[p]) win_nonce = base_of(p) + 32'(hit_round);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            round_q <= '0;
            drain_q <= '0;
            found_q <= 1'b0;
            nonce_q <= '0;
        end else begin
            state   <= state_n;
            round_q <= round_n;
            drain_q <= drain_n;
            found_q <= found_n;
            nonce_q <= nonce_n;
        end
    end

    always_comb begin
        state_n = state;
        round_n = round_q;
        drain_n = drain_q;
        found_n = found_q;
        nonce_n = nonce_q;
        flush   = 1'b0;
        unique case (state)
            IDLE: begin
                if (block_valid_i) begin
                    state_n = RUN;
                    round_n = '0;
                    flush   = 1'b1;
                end
            end
            RUN, DRAIN: begin
                // A new block beats any hit landing in the same cycle.
                if (block_valid_i) begin
                    state_n = RUN;
                    round_n = '0;
                    drain_n = '0;
                    flush   = 1'b1;
                end else if (|hit) begin
                    state_n = REPORT;
                    found_n = 1'b1;
                    nonce_n = win_nonce;
                    flush   = 1'b1;
                end else if (state == RUN) begin
                    if (round_q == LAST_ROUND) begin
                        state_n = DRAIN;
                        drain_n = '0;
                    end else begin
                        round_n = round_q + ROUNDBITS'(1);
                    end
                end else begin
                    if (drain_q == LAST_DRAIN) begin
                        state_n = REPORT;
                        found_n = 1'b0;
                        nonce_n = '0;
                    end else begin
                        drain_n = drain_q + DRAINBITS'(1);
                    end
                end
            end
            REPORT: begin
                if (result_ready_i) begin
                    state_n = IDLE;
                    found_n = 1'b0;
                    nonce_n = '0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_nonce_scheduler.sv
module tb_nonce_scheduler;

    localparam int N     = 10;
    localparam int SPACE = 64;
    localparam int D     = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          block_valid;
    logic          block_ready;
    logic          issue_valid;
    logic [2:0]    issue_round;
    logic [N-1:0]  issue_lane_en;
    logic [N-1:0]  success;
    logic          result_valid;
    logic          result_ready;
    logic          result_found;
    logic [31:0]   result_nonce;

    int checks   = 0;
    int failures = 0;

    int            cnt_ref  [N];
    logic [31:0]   base_ref [N];
    int            NR;
    logic [N-1:0]  succ [0:15];
    logic [N-1:0]  last_en;

    typedef struct {
        logic [N-1:0] mask;
        int           rnd;
        int           rdy_wait;
        logic         found;
        logic [31:0]  nonce;
    } vec_t;

    vec_t vecs [8];

    nonce_scheduler dut (
        .clk             (clk),
        .rst             (rst),
        .block_valid_i   (block_valid),
        .block_ready_o   (block_ready),
        .issue_valid_o   (issue_valid),
        .issue_round_o   (issue_round),
        .issue_lane_en_o (issue_lane_en),
        .success_i       (success),
        .result_valid_o  (result_valid),
        .result_ready_i  (result_ready),
        .result_found_o  (result_found),
        .result_nonce_o  (result_nonce)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [N-1:0] en_ref(input int r);
        logic [N-1:0] e;
        for (int p = 0; p < N; p++) e[p] = (r < cnt_ref[p]);
        return e;
    endfunction

    // Round r is issued in cycle r+1 after acceptance and its success arrives
    // in cycle r+1+D; the first round with an enabled hit wins, lowest lane first.
    task automatic model(output int kh, output logic f, output logic [31:0] n);
        logic [N-1:0] m;
        kh = 0; f = 1'b0; n = '0;
        for (int r = 0; r < NR; r++) begin
            m = succ[r+1+D] & en_ref(r);
            if (m != 0 && !f) begin
                f  = 1'b1;
                kh = r + 1 + D;
                for (int p = N - 1; p >= 0; p--) if (m[p]) n = base_ref[p] + r;
            end
        end
    endtask

    task automatic run_block(input int rdy_wait, output logic got_f, output logic [31:0] got_n);
        int          kh, kend;
        logic        ef;
        logic [31:0] en;
        bit          exp_iv;
        model(kh, ef, en);
        kend = ef ? kh + 1 : NR + D + 1;
        block_valid = 1'b1; step(); block_valid = 1'b0;
        for (int k = 1; k < kend; k++) begin
            exp_iv = (k <= NR) && (!ef || k <= kh);
            chk("issue_valid", issue_valid, exp_iv);
            chk("issue_round", issue_round, exp_iv ? k - 1 : 0);
            chk("issue_lane_en", issue_lane_en, exp_iv ? en_ref(k - 1) : '0);
            chk("early_result_valid", result_valid, 0);
            if (k == NR) last_en = issue_lane_en;
            success = succ[k]; step(); success = '0;
        end
        chk("result_valid", result_valid, 1);
        chk("result_found", result_found, ef);
        chk("result_nonce", result_nonce, en);
        chk("block_ready_in_report", block_ready, 0);
        got_f = result_found;
        got_n = result_nonce;
        for (int w = 0; w < rdy_wait; w++) begin
            step();
            chk("held_valid", result_valid, 1);
            chk("held_found", result_found, ef);
            chk("held_nonce", result_nonce, en);
            chk("held_block_ready", block_ready, 0);
        end
        result_ready = 1'b1; step(); result_ready = 1'b0;
        chk("post_handshake_valid", result_valid, 0);
        chk("post_handshake_ready", block_ready, 1);
    endtask

    task automatic clear_succ();
        for (int k = 0; k < 16; k++) succ[k] = '0;
    endtask

    initial begin
        logic        gf;
        logic [31:0] gn;
        int          acc;

        // Partition by handing out the nonce space lane by lane.
        acc = 0;
        for (int p = 0; p < N; p++) begin
            cnt_ref[p]  = SPACE / N + ((p < SPACE % N) ? 1 : 0);
            base_ref[p] = acc;
            acc        += cnt_ref[p];
        end
        NR = cnt_ref[0];

        vecs[0] = '{mask: 10'h000, rnd: 0, rdy_wait: 0, found: 1'b0, nonce: 32'd0};
        vecs[1] = '{mask: 10'h010, rnd: 2, rdy_wait: 5, found: 1'b1, nonce: 32'd30};
        vecs[2] = '{mask: 10'h082, rnd: 0, rdy_wait: 1, found: 1'b1, nonce: 32'd7};
        vecs[3] = '{mask: 10'h020, rnd: 6, rdy_wait: 0, found: 1'b0, nonce: 32'd0};
        vecs[4] = '{mask: 10'h200, rnd: 5, rdy_wait: 2, found: 1'b1, nonce: 32'd63};
        vecs[5] = '{mask: 10'h001, rnd: 6, rdy_wait: 0, found: 1'b1, nonce: 32'd6};
        vecs[6] = '{mask: 10'h008, rnd: 6, rdy_wait: 0, found: 1'b1, nonce: 32'd27};
        vecs[7] = '{mask: 10'h030, rnd: 6, rdy_wait: 0, found: 1'b0, nonce: 32'd0};

        rst = 1'b1; block_valid = 1'b0; success = '0; result_ready = 1'b0;
        clear_succ();
        step(); step();
        chk("rst_block_ready", block_ready, 1);
        chk("rst_issue_valid", issue_valid, 0);
        chk("rst_issue_round", issue_round, 0);
        chk("rst_lane_en", issue_lane_en, 0);
        chk("rst_result_valid", result_valid, 0);
        chk("rst_found", result_found, 0);
        chk("rst_nonce", result_nonce, 0);
        rst = 1'b0;
        step();

        // Plain sweep first, then the tail-round lane mask.
        clear_succ();
        run_block(0, gf, gn);
        chk("sweep_last_round_en", last_en, 10'b00_0000_1111);

        for (int i = 0; i < 8; i++) begin
            clear_succ();
            if (vecs[i].mask != 0) succ[vecs[i].rnd + 1 + D] = vecs[i].mask;
            run_block(vecs[i].rdy_wait, gf, gn);
            chk("tbl_found", gf, vecs[i].found);
            chk("tbl_nonce", gn, vecs[i].nonce);
        end

        // Preemption while round 3 is being issued; the old block's round-3
        // hit lands on the flushed pipeline and must vanish.
        block_valid = 1'b1; step(); block_valid = 1'b0;
        repeat (3) step();
        chk("pre_round3", issue_round, 3);
        block_valid = 1'b1; step(); block_valid = 1'b0;
        chk("preempt_restart_round", issue_round, 0);
        for (int k = 1; k < NR + D + 1; k++) begin
            chk("preempt_issue_valid", issue_valid, k <= NR);
            chk("preempt_no_result", result_valid, 0);
            success = (k == 4) ? '1 : '0;
            step();
            success = '0;
        end
        chk("preempt_result_valid", result_valid, 1);
        chk("preempt_found", result_found, 0);
        chk("preempt_nonce", result_nonce, 0);
        for (int w = 0; w < 5; w++) begin
            step();
            chk("bp_valid", result_valid, 1);
            chk("bp_block_ready", block_ready, 0);
        end
        result_ready = 1'b1; step(); result_ready = 1'b0;
        chk("preempt_done", result_valid, 0);

        // Asynchronous reset in the middle of DRAIN.
        block_valid = 1'b1; step(); block_valid = 1'b0;
        repeat (8) step();
        #2 rst = 1'b1;
        #1;
        chk("arst_block_ready", block_ready, 1);
        chk("arst_issue_valid", issue_valid, 0);
        chk("arst_result_valid", result_valid, 0);
        chk("arst_nonce", result_nonce, 0);
        step();
        rst = 1'b0;
        for (int w = 0; w < 14; w++) begin
            step();
            chk("arst_no_result", result_valid, 0);
            chk("arst_no_issue", issue_valid, 0);
        end
        clear_succ();
        succ[2 + 1 + D] = 10'h010;
        run_block(0, gf, gn);
        chk("after_rst_nonce", gn, 30);

        // Random sparse success patterns against the reference model.
        for (int t = 0; t < 40; t++) begin
            clear_succ();
            for (int k = 1; k <= NR + D; k++)
                if ($urandom_range(0, 3) == 0)
                    succ[k] = N'($urandom & $urandom & $urandom);
            run_block($urandom_range(0, 3), gf, gn);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
